astropix_spi_responder: RTL and testbench
=========================================

Name: astropix_spi_responder

Overview:
- Chip-side (slave) end of the per-row AstroPix readout SPI link: emulates one chip row for loopback and hardware-in-the-loop tests of the FPGA readout master.
- Accepts hit frames from a local pattern source into a frame FIFO and asserts interruptn while data is pending.
- Serialises frames on the dual-lane MISO when the master clocks SPI, and captures MOSI bytes for checking.
- All SPI pins are oversampled in the clk_core domain; no SPI-clocked logic.

Parameters:
- FRAME_BYTES, 5, payload bytes per hit frame (1..15)
- FIFO_DEPTH, 8, frames held (power of 2, ≥2)
- IDLE_BYTE, 8'hBC, byte sent when no frame is pending
- SYNC_STAGES, 2, input synchroniser depth

Ports:
- clk_core  in  1  core clock; must be ≥8× spi_clk
- rst  in  1  synchronous, active-high reset
- spi_clk  in  1  SPI clock from master (mode 0)
- spi_csn  in  1  chip select, active low
- spi_mosi  in  1  master→chip data
- spi_miso  out  2  chip→master data; [1]=even bit, [0]=odd bit
- interruptn  out  1  low = frame pending
- hold  in  1  high blocks acceptance of new frames
- hit_data  in  8*FRAME_BYTES  frame payload; byte 0 in MSBs
- hit_valid  in  1  payload valid
- hit_ready  out  1  = !fifo_full && !hold
- rx_byte  out  8  last captured MOSI byte
- rx_valid  out  1  1-cycle strobe per MOSI byte
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored
- frames_sent  out  16  completed frames, wraps at 16'hFFFF

Behaviour:
- Reset values: spi_miso=2'b11, interruptn=1, hit_ready=0 in the reset cycle, rx_byte=0, rx_valid=0, fifo_level=0, frames_sent=0. Reset also clears the FIFO, the frame index and the serialiser state.
- Synchronisation and edges: spi_clk, spi_csn and spi_mosi pass through SYNC_STAGES flops. Edges are detected on the synchronised signals.
  - Rise: sample MOSI.
  - Fall: advance MISO.
- Push: a frame is written when hit_valid && hit_ready.
  - Simultaneous push and pop: level unchanged.
  - Push while full is impossible, because hit_ready=0.
- Byte mapping: byte b goes out as 4 bit-pairs, k=0..3: miso[1]=b[7-2k], miso[0]=b[6-2k]. A byte therefore takes 4 SPI clocks.
- Byte select: at every byte boundary, in priority order:
  - Mid-frame (idx 1..FRAME_BYTES): send payload byte idx-1.
  - FIFO non-empty: pop one frame into the frame register and send header {4'hA, FRAME_BYTES[3:0]}; set idx=1.
  - Otherwise: send IDLE_BYTE.
- Frame completion: after the last payload byte, idx returns to 0 and frames_sent increments.
- Serialiser FSM states:
  - IDLE: csn high; miso=2'b11.
  - LOAD: one clk_core after the csn falling edge; select a byte, drive pair 0.
  - SHIFT:
    - Each spi_clk fall advances the pair.
    - After the fall following pair 3, go to LOAD-equivalent selection for the next byte; no gap, so the next byte's pair 0 is driven on that same fall.
    - csn rising → IDLE.
- csn deassert mid-byte: the partial byte is discarded.
  - If it was a payload or header byte, idx is kept and the same byte restarts from its MSB at the next csn assertion.
  - A popped frame is never lost.
  - A partial IDLE_BYTE is simply dropped.
- MOSI capture: an 8-bit shift register, MSB first, on rise.
  - On the 8th bit: rx_byte updates and rx_valid pulses for one cycle.
  - The counter clears on csn rising; partial bytes are discarded.
- interruptn = !(fifo_level!=0 || idx!=0), registered (one cycle after the state change).
- hold has no effect on frames already stored or on serialisation.
- Latency: MISO changes ≤ SYNC_STAGES+2 clk_core cycles after the physical spi_clk fall; hence the 8× clock ratio requirement.

Decomposition:
- Package astropix_emu_pkg:
  - IDLE_BYTE default
  - header nibble 4'hA
  - fsm state enum {IDLE, LOAD, SHIFT}
  - function hdr(frame_bytes)
- Sub-module astropix_frame_fifo: synchronous single-clock FIFO, width 8*FRAME_BYTES, depth FIFO_DEPTH, with full/empty/level outputs.
- Top level holds the synchronisers, edge detect, FSM and MOSI capture.

Test Plan:
- Empty FIFO, csn low, 16 SPI clocks → MISO reconstructs 0xBC,0xBC,0xBC,0xBC; interruptn stays 1.
- Push 40'h0102030405 (FRAME_BYTES=5), then 24 SPI clocks → bytes 0xA5,01,02,03,04,05; interruptn goes 0 one cycle after push and 1 after the last byte; frames_sent=1.
- Push 8 frames → hit_ready=0, fifo_level=8. Pop via one full frame read → level=7 and hit_ready returns to 1. Push and pop in the same cycle → level unchanged.
- csn released after 2 clocks of payload byte 0x03, then re-asserted → 0x03 resent in full, then 0x04, 0x05; frames_sent increments once.
- Master sends MOSI 0x5A, 0xC3 → rx_valid pulses twice, rx_byte=0x5A then 0xC3. A 5-bit partial byte followed by csn high → no strobe.
- hold=1 with hit_valid=1 → hit_ready=0, no push. Assert rst mid-frame → all outputs at reset values, next read returns 0xBC.

Source files
------------

// File: rtl/astropix_emu_pkg.sv
// Shared constants, state encodings and the frame header helper for the
// AstroPix row emulator.
package astropix_emu_pkg;

  localparam logic [7:0] IDLE_BYTE_DEF = 8'hBC;
  localparam logic [3:0] HDR_NIBBLE    = 4'hA;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} fsm_state_t;

  // What the byte currently in the serialiser is, so its completion can be retired.
  typedef enum logic [1:0] {K_IDLE, K_HDR, K_PAY} byte_kind_t;

  function automatic logic [7:0] hdr(input int frame_bytes);
    logic [3:0] n;
    n = 4'(frame_bytes);
    return {HDR_NIBBLE, n};
  endfunction

endpackage

// File: rtl/astropix_frame_fifo.sv
// Single-clock show-ahead FIFO holding complete hit frames.
module astropix_frame_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push+pop together leaves level alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/astropix_spi_responder.sv
// Chip-side SPI responder emulating one AstroPix row: frame FIFO, dual-lane
// MISO serialiser and MOSI byte capture, all oversampled in clk_core.
module astropix_spi_responder
  import astropix_emu_pkg::*;
#(
  parameter int         FRAME_BYTES = 5,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                         clk_core,
  input  logic                         rst,
  input  logic                         spi_clk,
  input  logic                         spi_csn,
  input  logic                         spi_mosi,
  output logic [1:0]                   spi_miso,
  output logic                         interruptn,
  input  logic                         hold,
  input  logic [8*FRAME_BYTES-1:0]     hit_data,
  input  logic                         hit_valid,
  output logic                         hit_ready,
  output logic [7:0]                   rx_byte,
  output logic                         rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                  frames_sent
);

  logic [SYNC_STAGES-1:0][2:0]   sync_q;
  logic                          clk_s, csn_s, mosi_s, clk_d, clk_rise, clk_fall;
  fsm_state_t                    state, state_nxt;
  byte_kind_t                    kind, sel_kind;
  logic [3:0]                    idx, c_idx;
  logic                          hdr_pend, c_hdr, fin, done, sel, pop;
  logic [1:0]                    pair;
  logic [7:0]                    shreg, sel_byte, pay_byte;
  logic [FRAME_BYTES-1:0][7:0]   frame_q;
  logic [8*FRAME_BYTES-1:0]      fifo_rdata;
  logic                          fifo_full, fifo_empty, push;
  logic [2:0]                    bit_cnt;
  logic [6:0]                    rx_sh;

  assign hit_ready = !fifo_full && !hold && !rst;
  assign push      = hit_valid && hit_ready;

  astropix_frame_fifo #(.WIDTH(8*FRAME_BYTES), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_core), .rst(rst), .push(push), .wdata(hit_data), .pop(pop),
    .rdata(fifo_rdata), .full(fifo_full), .empty(fifo_empty), .level(fifo_level)
  );

  // Synchronise {clk, csn, mosi}; csn resets high so no false select is seen.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{3'b010}};
      clk_d  <= 1'b0;
    end else begin
      sync_q[0] <= {spi_clk, spi_csn, spi_mosi};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      clk_d <= clk_s;
    end
  end

  assign {clk_s, csn_s, mosi_s} = sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s && !clk_d;
  assign clk_fall = !clk_s && clk_d;

  // FSM state register.
  always_ff @(posedge clk_core) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: csn high from any state drops the byte in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!csn_s) state_nxt = LOAD;
      LOAD:    state_nxt = csn_s ? IDLE : SHIFT;
      SHIFT:   if (csn_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output: lines idle high outside an active transfer.
  always_comb begin
    spi_miso = (state == SHIFT) ? shreg[7:6] : 2'b11;
  end

  assign done = (state == SHIFT) && !csn_s && clk_fall && (pair == 2'd3);
  assign sel  = ((state == LOAD) && !csn_s) || done;

  // Retire the byte just finished, then pick the next byte from the updated position.
  always_comb begin
    c_idx = idx;
    c_hdr = hdr_pend;
    fin   = 1'b0;
    if (done) begin
      if (kind == K_HDR) c_hdr = 1'b0;
      else if (kind == K_PAY) begin
        if (idx == 4'(FRAME_BYTES)) begin
          c_idx = '0;
          fin   = 1'b1;
        end else c_idx = idx + 4'd1;
      end
    end
    pay_byte = '0;
    for (int i = 0; i < FRAME_BYTES; i++)
      if (c_idx == 4'(i + 1)) pay_byte = frame_q[FRAME_BYTES-1-i];
    pop = 1'b0;
    if (c_idx != '0) begin
      sel_kind = c_hdr ? K_HDR : K_PAY;
      sel_byte = c_hdr ? hdr(FRAME_BYTES) : pay_byte;
    end else if (!fifo_empty) begin
      pop      = sel;
      sel_kind = K_HDR;
      sel_byte = hdr(FRAME_BYTES);
    end else begin
      sel_kind = K_IDLE;
      sel_byte = IDLE_BYTE;
    end
  end

  // Serialiser datapath; idx only moves when a byte fully completes, so an
  // aborted byte (including a header of an already-popped frame) is resent.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      idx         <= '0;
      hdr_pend    <= 1'b0;
      kind        <= K_IDLE;
      pair        <= '0;
      shreg       <= '1;
      frame_q     <= '0;
      frames_sent <= '0;
    end else begin
      if (sel) begin
        kind     <= sel_kind;
        shreg    <= sel_byte;
        pair     <= '0;
        idx      <= pop ? 4'd1 : c_idx;
        hdr_pend <= pop ? 1'b1 : c_hdr;
      end else if ((state == SHIFT) && !csn_s && clk_fall) begin
        shreg <= {shreg[5:0], 2'b00};
        pair  <= pair + 2'd1;
      end
      if (pop) frame_q <= fifo_rdata;
      if (fin) frames_sent <= frames_sent + 16'd1;
    end
  end

  // MOSI capture, MSB first on rising edges; deselect discards a partial byte.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      bit_cnt  <= '0;
      rx_sh    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (csn_s) bit_cnt <= '0;
      else if (clk_rise) begin
        rx_sh   <= {rx_sh[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte  <= {rx_sh, mosi_s};
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // Pending-data interrupt, registered.
  always_ff @(posedge clk_core) begin
    if (rst) interruptn <= 1'b1;
    else     interruptn <= !((fifo_level != '0) || (idx != '0));
  end

endmodule

// File: tb/tb_astropix_spi_responder.sv
// Scoreboard bench: a byte-level model of the frame stream predicts every MISO
// byte and every MOSI capture; monitors reconstruct DUT output and compare.
module tb_astropix_spi_responder;

  localparam int FB    = 5;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int HALF  = 8;

  logic            clk_core = 1'b0;
  logic            rst = 1'b0, spi_clk = 1'b0, spi_csn = 1'b1, spi_mosi = 1'b0;
  logic            hold = 1'b0, hit_valid = 1'b0;
  logic [8*FB-1:0] hit_data = '0;
  logic [1:0]      spi_miso;
  logic            interruptn, hit_ready, rx_valid;
  logic [7:0]      rx_byte;
  logic [LW-1:0]   fifo_level;
  logic [15:0]     frames_sent;

  astropix_spi_responder #(.FRAME_BYTES(FB), .FIFO_DEPTH(DEPTH), .IDLE_BYTE(8'hBC), .SYNC_STAGES(2)) dut (
    .clk_core(clk_core), .rst(rst), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .interruptn(interruptn), .hold(hold), .hit_data(hit_data),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .fifo_level(fifo_level), .frames_sent(frames_sent)
  );

  always #5 clk_core = ~clk_core;

  int n_tests = 0, n_fail = 0;

  logic [7:0]      exp_miso[$];
  logic [7:0]      exp_rx[$];
  logic [8*FB-1:0] fifo_m[$];
  logic [7:0]      byteq[$];
  int              sent_m = 0;
  logic [7:0]      rx_acc;
  int              rx_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Master-side deserialiser: four pairs per byte, reset by deselect.
  logic [7:0] acc;
  int         npair = 0;
  always @(posedge spi_clk or posedge spi_csn) begin
    if (spi_csn) npair = 0;
    else begin
      acc = {acc[5:0], spi_miso};
      npair++;
      if (npair == 4) begin
        npair = 0;
        if (exp_miso.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL miso_unexpected: got %0h expected none", acc);
        end else check("miso_byte", 32'(acc), 32'(exp_miso.pop_front()));
      end
    end
  end

  // MOSI capture monitor.
  always @(negedge clk_core) begin
    if (rx_valid === 1'b1) begin
      if (exp_rx.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rx_unexpected: got %0h expected none", rx_byte);
      end else check("rx_byte", 32'(rx_byte), 32'(exp_rx.pop_front()));
    end
  end

  // Model: the byte at a boundary is the next frame byte, expanding a stored
  // frame into header+payload when none is in progress, else the idle byte.
  task automatic m_peek(output logic [7:0] b);
    logic [8*FB-1:0] f;
    if (byteq.size() == 0 && fifo_m.size() != 0) begin
      f = fifo_m.pop_front();
      byteq.push_back({4'hA, 4'(FB)});
      for (int k = 0; k < FB; k++) byteq.push_back(f[8*(FB-1-k) +: 8]);
    end
    b = (byteq.size() != 0) ? byteq[0] : 8'hBC;
  endtask

  task automatic m_done();
    if (byteq.size() != 0) begin
      byteq.delete(0);
      if (byteq.size() == 0) sent_m++;
    end
  endtask

  function automatic logic [8*FB-1:0] rand_frame();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[8*FB-1:0];
  endfunction

  task automatic spi_clock(input logic b);
    spi_mosi = b;
    rx_acc = {rx_acc[6:0], b};
    rx_cnt++;
    if (rx_cnt == 8) begin
      exp_rx.push_back(rx_acc);
      rx_cnt = 0;
    end
    repeat (HALF) @(posedge clk_core);
    #1 spi_clk = 1'b1;
    repeat (HALF) @(posedge clk_core);
    #1 spi_clk = 1'b0;
  endtask

  task automatic session(input int nfull, input int npart, input logic [31:0] mo, input bit fixed);
    logic [7:0] b;
    int nb = 0;
    @(posedge clk_core);
    #1 spi_csn = 1'b0;
    rx_cnt = 0;
    m_peek(b);
    repeat (HALF) @(posedge clk_core);
    for (int j = 0; j < nfull; j++) begin
      m_peek(b);
      exp_miso.push_back(b);
      for (int k = 0; k < 4; k++) begin
        spi_clock((fixed && nb < 32) ? mo[31-nb] : 1'($urandom()));
        nb++;
      end
      m_done();
      m_peek(b);
    end
    for (int k = 0; k < npart; k++) begin
      spi_clock((fixed && nb < 32) ? mo[31-nb] : 1'($urandom()));
      nb++;
    end
    repeat (HALF) @(posedge clk_core);
    #1 spi_csn = 1'b1;
    repeat (12) @(posedge clk_core);
  endtask

  task automatic push(input logic [8*FB-1:0] d, input bit hld);
    bit exp_rdy;
    exp_rdy = (fifo_m.size() < DEPTH) && !hld;
    @(posedge clk_core);
    #1 hit_data = d; hit_valid = 1'b1; hold = hld;
    @(negedge clk_core);
    check(hld ? "hold_ready" : "push_ready", 32'(hit_ready), 32'(exp_rdy));
    @(posedge clk_core);
    #1 hit_valid = 1'b0; hold = 1'b0;
    if (exp_rdy) fifo_m.push_back(d);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk_core);
    check({tag, "_level"}, 32'(fifo_level), 32'(fifo_m.size()));
    check({tag, "_irqn"},  32'(interruptn), 32'(fifo_m.size() == 0 && byteq.size() == 0));
    check({tag, "_sent"},  32'(frames_sent), 32'(16'(sent_m)));
    check({tag, "_ready"}, 32'(hit_ready), 32'(fifo_m.size() < DEPTH));
  endtask

  task automatic do_reset();
    @(posedge clk_core);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk_core);
    @(negedge clk_core);
    check("rst_miso",  32'(spi_miso), 32'd3);
    check("rst_irqn",  32'(interruptn), 32'd1);
    check("rst_ready", 32'(hit_ready), 32'd0);
    check("rst_rxb",   32'(rx_byte), 32'd0);
    check("rst_rxv",   32'(rx_valid), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_sent",  32'(frames_sent), 32'd0);
    @(posedge clk_core);
    #1 rst = 1'b0;
    fifo_m.delete();
    byteq.delete();
    sent_m = 0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Empty FIFO: idle bytes only.
    session(4, 0, 32'h0, 1'b0);
    check_state("idle");

    // One known frame, interrupt timing.
    push(40'h0102030405, 1'b0);
    @(negedge clk_core);
    check("irqn_lag", 32'(interruptn), 32'd1);
    @(negedge clk_core);
    check("irqn_set", 32'(interruptn), 32'd0);
    session(6, 0, 32'h0, 1'b0);
    check_state("frame1");
    check("frames_sent_1", 32'(frames_sent), 32'd1);

    // Push aimed at the pop cycle of a session start.
    push(rand_frame(), 1'b0);
    fork
      session(6, 0, 32'h0, 1'b0);
      begin
        repeat (3) @(posedge clk_core);
        push(rand_frame(), 1'b0);
      end
    join
    check_state("pushpop");

    // Fill, reject while full, then free one slot.
    for (int i = 0; i < DEPTH; i++) push(rand_frame(), 1'b0);
    check_state("full");
    push(rand_frame(), 1'b0);
    session(6, 0, 32'h0, 1'b0);
    check_state("pop_one");

    // Drain everything plus one idle byte.
    session(byteq.size() + 6 * fifo_m.size() + 1, 0, 32'h0, 1'b0);
    check_state("drain");

    // Deselect two clocks into a payload byte, then resume.
    push(40'h0102030405, 1'b0);
    session(3, 2, 32'h0, 1'b0);
    check_state("abort");
    session(3, 0, 32'h0, 1'b0);
    check_state("resume");

    // MOSI capture: two bytes, then a 5-bit partial.
    session(4, 0, 32'h5AC3_0000, 1'b1);
    session(1, 1, 32'h0, 1'b0);
    @(negedge clk_core);
    check("rx_last", 32'(rx_byte), 32'h0000_00C3);

    // hold blocks acceptance.
    push(rand_frame(), 1'b1);
    check_state("hold");

    // Randomised traffic, including header and idle aborts.
    for (int it = 0; it < 16; it++) begin
      int np;
      np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) push(rand_frame(), ($urandom_range(0, 3) == 0));
      session($urandom_range(0, 7), $urandom_range(0, 3), 32'h0, 1'b0);
      check_state("rand");
    end

    // Reset in the middle of a frame.
    push(rand_frame(), 1'b0);
    session(2, 0, 32'h0, 1'b0);
    do_reset();
    session(1, 0, 32'h0, 1'b0);
    check_state("post_rst");

    repeat (4) @(negedge clk_core);
    check("miso_q_empty", 32'(exp_miso.size()), 32'd0);
    check("rx_q_empty",   32'(exp_rx.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
